// File: rtl/print_bus_pkg.sv
// Shared definitions for the print burst master.
//   state_e     : FSM state encoding (idle, request, begin, data, end)
//   bus_out_t   : bundle of every bus-side output driven by the master
//   BusIdle     : all-zero bus bundle, driven whenever the master does not own
//                 the bus. The bus is wired-OR, so idle outputs must be exactly 0.
//   burst_size(): beats -> BURST_SIZE field encoding (beats-1)
package print_bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StBegin,
        StData,
        StEnd
    } state_e;

    typedef struct packed {
        logic [31:0] addr_data;
        logic [3:0]  byte_enables;
        logic [7:0]  size;
        logic        read_n_write;
        logic        begin_txn;
        logic        end_txn;
        logic        data_valid;
    } bus_out_t;

    localparam bus_out_t   BusIdle     = '0;
    localparam logic [3:0] BusAllBytes = 4'hF;

    // The bus encodes burst length as beats-1; a 1-beat burst is size 0.
    function automatic logic [7:0] burst_size(input logic [7:0] beats);
        return beats - 8'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered occupancy count.
//   clk       : clock, all state on rising edge
//   rst_n     : synchronous active-low reset, empties the FIFO
//   push      : write push_data (caller guarantees not full)
//   push_data : word to store
//   pop       : drop the head entry (caller guarantees not empty)
//   head      : oldest stored word (undefined while empty)
//   count     : number of stored words, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Storage needs no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/print_burst_master.sv
// Print burst master: buffers 32-bit words pushed by the core and drains them
// as write bursts (begin, data beats, end) to the print slave at BASE_ADDR.
//   clk_i                  : clock
//   rst_n_i                : synchronous active-low reset
//   push_valid_i/data_i    : core word offer, taken when push_ready_o is high
//   push_ready_o           : FIFO not full (registered count, no pop bypass)
//   flush_i                : pulse, emit everything buffered
//   request_o / grant_i    : arbiter handshake; request held REQ..END
//   bus_busy_i             : stalls the current data beat
//   bus_*_o                : wired-OR bus outputs, zero unless owning the bus
//   idle_o                 : FSM idle and FIFO empty
module print_burst_master
    import print_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h5000_0000,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned MAX_BURST  = 8,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        push_valid_i,
    input  logic [31:0] push_data_i,
    output logic        push_ready_o,
    input  logic        flush_i,
    output logic        request_o,
    input  logic        grant_i,
    input  logic        bus_busy_i,
    output logic [31:0] bus_addrData_o,
    output logic [3:0]  bus_byteEnables_o,
    output logic [7:0]  bus_burstSize_o,
    output logic        bus_readNWrite_o,
    output logic        bus_beginTransaction_o,
    output logic        bus_endTransaction_o,
    output logic        bus_dataValid_o,
    output logic        idle_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LW = $clog2(MAX_BURST + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] DepthC    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MaxBurstC = CW'(MAX_BURST);
    localparam logic [LW-1:0] MaxLenC   = LW'(MAX_BURST);
    localparam logic [TW-1:0] TimeoutC  = TW'(TIMEOUT);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] count;
    logic [31:0]   head;
    logic          push_fire;
    logic          pop;
    logic          trigger;
    logic          last_beat;
    logic          flush_q;
    logic          flush_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic [LW-1:0] len_q;
    logic [LW-1:0] beat_q;
    bus_out_t      bus;

    assign push_ready_o = (count < DepthC);
    assign push_fire    = push_valid_i && push_ready_o;
    assign pop          = (state_q == StData) && !bus_busy_i;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (push_fire),
        .push_data (push_data_i),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    // A burst starts on a full burst's worth, on flush, or when a partial
    // burst has sat untouched for TIMEOUT cycles.
    assign trigger = (count != '0) &&
                     ((count >= MaxBurstC) || flush_q || (timer_q == TimeoutC));

    assign last_beat = ((beat_q + LW'(1)) == len_q);

    // Flush stays pending across back-to-back bursts until the FIFO runs dry
    // in IDLE; a new flush pulse wins over the clear.
    assign flush_d = flush_i || (flush_q && !((state_q == StIdle) && (count == '0)));

    always_comb begin
        timer_d = timer_q;
        if ((state_q != StIdle) || (count == '0) || push_fire) begin
            timer_d = '0;
        end else if (timer_q != TimeoutC) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (trigger) state_d = StReq;
            StReq:   if (grant_i) state_d = StBegin;
            StBegin: state_d = StData;
            StData:  if (pop && last_beat) state_d = StEnd;
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Burst bookkeeping: length fixed on the grant edge, beats counted in DATA.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            flush_q <= 1'b0;
            timer_q <= '0;
            len_q   <= '0;
            beat_q  <= '0;
        end else begin
            flush_q <= flush_d;
            timer_q <= timer_d;
            if ((state_q == StReq) && grant_i) begin
                len_q <= (count >= MaxBurstC) ? MaxLenC : LW'(count);
            end
            if (state_q == StBegin) begin
                beat_q <= '0;
            end else if (pop) begin
                beat_q <= beat_q + LW'(1);
            end
        end
    end

    // Output logic
    always_comb begin
        bus       = BusIdle;
        request_o = (state_q != StIdle);
        idle_o    = (state_q == StIdle) && (count == '0);
        unique case (state_q)
            StBegin: begin
                bus.begin_txn    = 1'b1;
                bus.addr_data    = BASE_ADDR;
                bus.byte_enables = BusAllBytes;
                bus.size         = burst_size(8'(len_q));
            end
            StData: begin
                bus.data_valid = 1'b1;
                bus.addr_data  = head;
            end
            StEnd: begin
                bus.end_txn = 1'b1;
            end
            default: begin
                bus = BusIdle;
            end
        endcase
    end

    assign bus_addrData_o         = bus.addr_data;
    assign bus_byteEnables_o      = bus.byte_enables;
    assign bus_burstSize_o        = bus.size;
    assign bus_readNWrite_o       = bus.read_n_write;
    assign bus_beginTransaction_o = bus.begin_txn;
    assign bus_endTransaction_o   = bus.end_txn;
    assign bus_dataValid_o        = bus.data_valid;

endmodule

// File: tb/tb_print_burst_master.sv
// Bench for print_burst_master: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.
module tb_print_burst_master;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          DEPTH = 16;
    localparam int          MAXB  = 8;
    localparam int          TMO   = 64;

    localparam int P_IDLE  = 0;
    localparam int P_REQ   = 1;
    localparam int P_BEGIN = 2;
    localparam int P_DATA  = 3;
    localparam int P_END   = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push_valid;
    logic [31:0] push_data;
    logic        flush;
    logic        grant;
    logic        busy;

    logic        push_ready_o;
    logic        request_o;
    logic [31:0] bus_addrData_o;
    logic [3:0]  bus_byteEnables_o;
    logic [7:0]  bus_burstSize_o;
    logic        bus_readNWrite_o;
    logic        bus_beginTransaction_o;
    logic        bus_endTransaction_o;
    logic        bus_dataValid_o;
    logic        idle_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    print_burst_master dut (
        .clk_i                  (clk),
        .rst_n_i                (rst_n),
        .push_valid_i           (push_valid),
        .push_data_i            (push_data),
        .push_ready_o           (push_ready_o),
        .flush_i                (flush),
        .request_o              (request_o),
        .grant_i                (grant),
        .bus_busy_i             (busy),
        .bus_addrData_o         (bus_addrData_o),
        .bus_byteEnables_o      (bus_byteEnables_o),
        .bus_burstSize_o        (bus_burstSize_o),
        .bus_readNWrite_o       (bus_readNWrite_o),
        .bus_beginTransaction_o (bus_beginTransaction_o),
        .bus_endTransaction_o   (bus_endTransaction_o),
        .bus_dataValid_o        (bus_dataValid_o),
        .idle_o                 (idle_o)
    );

    // ---------------- behavioural model ----------------
    int unsigned mq[$];        // words buffered, oldest first
    int          m_phase = P_IDLE;
    bit          m_flush = 0;
    int          m_timer = 0;
    int          m_len   = 0;
    int          m_beats = 0;
    bit          m_valid = 0;
    int unsigned acc_log[$];   // every accepted word, push order
    int unsigned beat_log[$];  // every completed data beat seen on the bus
    int unsigned size_log[$];  // burstSize of every begin strobe

    always @(posedge clk) begin
        int cnt;
        bit acc;
        bit pop;
        bit trig;
        int nxt;
        if (!rst_n) begin
            mq.delete();
            acc_log.delete();
            beat_log.delete();
            m_phase = P_IDLE;
            m_flush = 0;
            m_timer = 0;
            m_len   = 0;
            m_beats = 0;
            m_valid = 1;
        end else if (m_valid) begin
            cnt  = mq.size();
            acc  = push_valid && (cnt < DEPTH);
            pop  = (m_phase == P_DATA) && !busy;
            trig = (cnt > 0) && ((cnt >= MAXB) || m_flush || (m_timer == TMO));
            nxt  = m_phase;
            case (m_phase)
                P_IDLE:  if (trig) nxt = P_REQ;
                P_REQ:   if (grant) begin
                    nxt   = P_BEGIN;
                    m_len = (cnt < MAXB) ? cnt : MAXB;
                end
                P_BEGIN: begin
                    nxt     = P_DATA;
                    m_beats = 0;
                end
                P_DATA:  if (pop) begin
                    m_beats++;
                    if (m_beats == m_len) nxt = P_END;
                end
                default: nxt = P_IDLE;
            endcase
            if ((m_phase != P_IDLE) || (cnt == 0) || acc) m_timer = 0;
            else if (m_timer < TMO) m_timer++;
            m_flush = flush || (m_flush && !((m_phase == P_IDLE) && (cnt == 0)));
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(push_data);
                acc_log.push_back(push_data);
            end
            m_phase = nxt;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [50:0] exp_v;
        logic [50:0] act_v;
        logic [31:0] exp_addr;
        if (bus_dataValid_o === 1'b1 && busy === 1'b0) beat_log.push_back(bus_addrData_o);
        if (bus_beginTransaction_o === 1'b1) size_log.push_back(32'(bus_burstSize_o));
        if (m_valid) begin
            exp_addr = 32'h0;
            if (m_phase == P_BEGIN) exp_addr = BASE;
            else if (m_phase == P_DATA && mq.size() > 0) exp_addr = mq[0];
            exp_v = {m_phase != P_IDLE, mq.size() < DEPTH,
                     (m_phase == P_IDLE) && (mq.size() == 0),
                     m_phase == P_BEGIN, m_phase == P_END, m_phase == P_DATA, 1'b0,
                     (m_phase == P_BEGIN) ? 4'hF : 4'h0,
                     (m_phase == P_BEGIN) ? 8'(m_len - 1) : 8'h0,
                     exp_addr};
            act_v = {request_o, push_ready_o, idle_o, bus_beginTransaction_o,
                     bus_endTransaction_o, bus_dataValid_o, bus_readNWrite_o,
                     bus_byteEnables_o, bus_burstSize_o, bus_addrData_o};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got %h want %h", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return bus_beginTransaction_o;
            1:       return bus_dataValid_o;
            2:       return idle_o;
            default: return request_o;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int limit, input string name);
        int n = 0;
        while (sig_sel(sel) !== 1'b1 && n < limit) begin
            cyc();
            n++;
        end
        if (sig_sel(sel) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got none want strobe within %0d cycles", name, limit);
        end
    endtask

    task automatic check_log(input string name, input int base, input int n,
                             input int unsigned first);
        checks++;
        if (beat_log.size() != base + n) begin
            errors++;
            $display("FAIL %s_count got %0d want %0d", name, beat_log.size() - base, n);
        end else begin
            for (int i = 0; i < n; i++) check(name, beat_log[base + i], first + i);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        push_valid = 1'b1;
        push_data  = w;
        cyc();
        push_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        flush      = 1'b0;
        grant      = 1'b0;
        busy       = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;

        check("rst_request", 32'(request_o), 32'd0);
        check("rst_ready", 32'(push_ready_o), 32'd1);
        check("rst_idle", 32'(idle_o), 32'd1);
        check("rst_addr", bus_addrData_o, 32'd0);

        // Full burst of 8 with immediate grant.
        grant = 1'b1;
        base  = beat_log.size();
        for (int i = 1; i <= 8; i++) push_word(32'(i));
        wait_for(0, 20, "t1_begin");
        check("t1_size", 32'(bus_burstSize_o), 32'd7);
        check("t1_addr", bus_addrData_o, BASE);
        check("t1_be", 32'(bus_byteEnables_o), 32'hF);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            check("t1_beat", bus_addrData_o, 32'(i));
        end
        cyc();
        check("t1_end", 32'(bus_endTransaction_o), 32'd1);
        cyc();
        check("t1_idle", 32'(idle_o), 32'd1);
        check_log("t1_log", base, 8, 32'd1);

        // Partial burst forced out by the idle timer: 64 counted idle cycles,
        // then one more edge to enter REQ.
        base = beat_log.size();
        for (int i = 0; i < 3; i++) push_word(32'hA0 + 32'(i));
        n = 0;
        while (request_o !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        check("t2_req_delay", 32'(n), 32'd65);
        wait_for(0, 20, "t2_begin");
        check("t2_size", 32'(bus_burstSize_o), 32'd2);
        wait_for(2, 40, "t2_idle");
        check_log("t2_log", base, 3, 32'hA0);

        // 20 words then flush: bursts of 8, 8, 4.
        size_log.delete();
        base = beat_log.size();
        for (int i = 0; i < 20; i++) push_word(32'd100 + 32'(i));
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_for(2, 200, "t3_idle");
        check("t3_nbursts", 32'(size_log.size()), 32'd3);
        if (size_log.size() == 3) begin
            check("t3_size0", size_log[0], 32'd7);
            check("t3_size1", size_log[1], 32'd7);
            check("t3_size2", size_log[2], 32'd3);
        end
        check_log("t3_log", base, 20, 32'd100);

        // Fill with no grant; 17th word held until the first pop frees a slot.
        grant = 1'b0;
        base  = beat_log.size();
        for (int i = 0; i < 16; i++) push_word(32'd200 + 32'(i));
        check("t4_full_ready", 32'(push_ready_o), 32'd0);
        push_valid = 1'b1;
        push_data  = 32'd216;
        repeat (3) cyc();
        check("t4_held_ready", 32'(push_ready_o), 32'd0);
        grant = 1'b1;
        n = 0;
        while (push_ready_o !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        check("t4_ready_back", 32'(push_ready_o), 32'd1);
        cyc();
        push_valid = 1'b0;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        wait_for(2, 200, "t4_idle");
        check_log("t4_log", base, 17, 32'd200);

        // Busy stall on beat 2 for three cycles.
        base = beat_log.size();
        for (int i = 0; i < 8; i++) push_word(32'd300 + 32'(i));
        wait_for(1, 20, "t5_data");
        check("t5_beat1", bus_addrData_o, 32'd300);
        cyc();
        busy = 1'b1;
        check("t5_beat2", bus_addrData_o, 32'd301);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t5_stall_dv", 32'(bus_dataValid_o), 32'd1);
            check("t5_stall_word", bus_addrData_o, 32'd301);
        end
        busy = 1'b0;
        wait_for(2, 40, "t5_idle");
        check_log("t5_log", base, 8, 32'd300);

        // Reset in the middle of a burst.
        for (int i = 0; i < 8; i++) push_word(32'd400 + 32'(i));
        wait_for(1, 20, "t6_data");
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        check("t6_request", 32'(request_o), 32'd0);
        check("t6_addr", bus_addrData_o, 32'd0);
        check("t6_dv", 32'(bus_dataValid_o), 32'd0);
        check("t6_end", 32'(bus_endTransaction_o), 32'd0);
        check("t6_ready", 32'(push_ready_o), 32'd1);
        check("t6_idle", 32'(idle_o), 32'd1);

        // Randomized traffic: alternate busy bursts and sparse pushes so the
        // timeout, full FIFO and stall paths all get exercised.
        for (int blk = 0; blk < 16; blk++) begin
            for (int c = 0; c < 250; c++) begin
                push_valid = (blk % 2 == 0) ? ($urandom_range(0, 99) < 60)
                                            : ($urandom_range(0, 99) < 2);
                push_data  = $urandom;
                grant      = (blk % 4 == 2) ? ($urandom_range(0, 99) < 3)
                                            : ($urandom_range(0, 3) != 0);
                busy       = ($urandom_range(0, 3) == 0);
                flush      = ($urandom_range(0, 59) == 0);
                rst_n      = ($urandom_range(0, 1999) != 0);
                cyc();
            end
        end
        rst_n      = 1'b1;
        push_valid = 1'b0;
        busy       = 1'b0;
        grant      = 1'b1;
        flush      = 1'b1;
        cyc();
        flush = 1'b0;
        wait_for(2, 500, "drain_idle");

        // End-to-end: every accepted word appears exactly once, in order.
        check("e2e_count", 32'(beat_log.size()), 32'(acc_log.size()));
        if (beat_log.size() == acc_log.size()) begin
            n = -1;
            for (int i = 0; i < acc_log.size(); i++) begin
                if (n < 0 && beat_log[i] != acc_log[i]) n = i;
            end
            checks++;
            if (n >= 0) begin
                errors++;
                $display("FAIL e2e_order index %0d got %h want %h", n, beat_log[n], acc_log[n]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
